// File: rtl/bram_lut_sched.sv
// rtl/bram_lut_sched.sv - round-robin scheduler sharing a dual-port BRAM lookup table between four requesters
module bram_lut_sched #(
  parameter int NREQ = 4,
  parameter int LAT  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [10*NREQ-1:0]   addr,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [8*NREQ-1:0]    rsp_data,
  output logic [9:0]           ADDRA,
  output logic [9:0]           ADDRB,
  output logic                 EN,
  output logic                 bram_rst,
  input  logic [7:0]           DOA,
  input  logic [7:0]           DOB,
  output logic                 idle
);

  typedef struct packed {
    logic       va;
    logic [1:0] ida;
    logic       vb;
    logic [1:0] idb;
  } tag_t;

  logic [1:0]       ptr;
  logic [1:0]       idx;
  logic             va, vb;
  logic [1:0]       ida, idb;
  logic             busy;
  tag_t             tag_in;
  tag_t             last;
  tag_t [LAT-1:0]   tags;

  // First two requesters found scanning up from ptr win ports A and B.
  always_comb begin
    gnt   = '0;
    ADDRA = '0;
    ADDRB = '0;
    va    = 1'b0;
    vb    = 1'b0;
    ida   = '0;
    idb   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + 2'(k);
      if (rst && req[idx]) begin
        if (!va) begin
          va  = 1'b1;
          ida = idx;
        end else if (!vb) begin
          vb  = 1'b1;
          idb = idx;
        end
      end
    end
    if (va) begin
      gnt[ida] = 1'b1;
      ADDRA    = addr[10*int'(ida) +: 10];
    end
    if (vb) begin
      gnt[idb] = 1'b1;
      ADDRB    = addr[10*int'(idb) +: 10];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    ptr <= '0;
    else if (vb) ptr <= idb + 2'd1;
    else if (va) ptr <= ida + 2'd1;
  end

  assign tag_in = {va, ida, vb, idb};
  assign last   = tags[LAT-1];

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LAT; i++) busy = busy | tags[i].va | tags[i].vb;
  end

  assign EN       = rst & ((|req) | busy);
  assign idle     = ~EN;
  assign bram_rst = ~rst;

  // Tags march in step with the BRAM's address and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tags <= '0;
    end else if (EN) begin
      tags[0] <= tag_in;
      for (int i = 1; i < LAT; i++) tags[i] <= tags[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= '0;
      if (last.va) begin
        rsp_valid[last.ida]               <= 1'b1;
        rsp_data[8*int'(last.ida) +: 8]   <= DOA;
      end
      if (last.vb) begin
        rsp_valid[last.idb]               <= 1'b1;
        rsp_data[8*int'(last.idb) +: 8]   <= DOB;
      end
    end
  end

endmodule

// File: tb/tb_bram_lut_sched.sv
// tb/tb_bram_lut_sched.sv - self-checking bench for bram_lut_sched
module tb_bram_lut_sched;
  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic [3:0]  req  = '0;
  logic [39:0] addr = '0;
  logic [3:0]  gnt, rsp_valid;
  logic [31:0] rsp_data;
  logic [9:0]  ADDRA, ADDRB;
  logic        EN, bram_rst, idle;
  logic [7:0]  DOA, DOB;

  bram_lut_sched #(.NREQ(4), .LAT(2)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .ADDRA(ADDRA), .ADDRB(ADDRB),
    .EN(EN), .bram_rst(bram_rst), .DOA(DOA), .DOB(DOB), .idle(idle)
  );

  always #5 clk = ~clk;

  // Dual-port BRAM: registered address plus output register, both on EN.
  logic [7:0] mem [0:1023];
  logic [9:0] ra, rb;
  always @(posedge clk) if (EN) begin ra <= ADDRA; rb <= ADDRB; end
  always @(posedge clk or posedge bram_rst)
    if (bram_rst) begin DOA <= '0; DOB <= '0; end
    else if (EN) begin DOA <= mem[ra]; DOB <= mem[rb]; end

  int tests = 0;
  int fails = 0;
  int cyc;
  int ptr_m;
  logic [3:0]  sch_v [0:4095];
  logic [7:0]  sch_d [0:4095][0:3];
  logic        ghist [0:4095];
  logic [7:0]  lane_m [0:3];
  logic [3:0]  s_rv;
  logic [31:0] s_rd;
  logic        s_en;
  logic [9:0]  s_a, s_b;

  typedef struct {
    logic [3:0] r;
    logic [3:0] g;
    logic [9:0] a;
    logic [9:0] b;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4096; i++) begin sch_v[i] = '0; ghist[i] = 1'b0; end
    for (int i = 0; i < 4; i++) lane_m[i] = '0;
    ptr_m = 0;
    cyc   = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = 4'hF;
    #1;
    chk("reset_en", EN, 0);
    chk("reset_idle", idle, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_bram_rst", bram_rst, 1);
    @(negedge clk);
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    model_clear();
  endtask

  // One clock cycle: apply inputs, check against the reference model, advance it.
  task automatic step(input logic [3:0] r, input logic [39:0] a, output logic [3:0] g);
    int ida, idb;
    logic [3:0]  eg;
    logic [9:0]  ea, eb;
    logic        en_e;
    logic [31:0] ed;
    @(negedge clk);
    req  = r;
    addr = a;
    #1;
    ida = -1;
    idb = -1;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (ptr_m + k) % 4;
      if (r[i]) begin
        if (ida < 0) ida = i;
        else if (idb < 0) idb = i;
      end
    end
    eg = '0; ea = '0; eb = '0;
    if (ida >= 0) begin eg[ida] = 1'b1; ea = a[10*ida +: 10]; end
    if (idb >= 0) begin eg[idb] = 1'b1; eb = a[10*idb +: 10]; end
    for (int i = 0; i < 4; i++) if (sch_v[cyc][i]) lane_m[i] = sch_d[cyc][i];
    ed   = {lane_m[3], lane_m[2], lane_m[1], lane_m[0]};
    en_e = (|r) || (cyc >= 1 ? ghist[cyc-1] : 1'b0) || (cyc >= 2 ? ghist[cyc-2] : 1'b0);
    chk("gnt", gnt, eg);
    chk("addr_ab", {ADDRA, ADDRB}, {ea, eb});
    chk("en", EN, en_e);
    chk("idle", idle, !en_e);
    chk("rsp_valid", rsp_valid, sch_v[cyc]);
    chk("rsp_data", rsp_data, ed);
    s_rv = rsp_valid; s_rd = rsp_data; s_en = EN; s_a = ADDRA; s_b = ADDRB;
    g = gnt;
    if (ida >= 0) begin
      ghist[cyc] = 1'b1;
      sch_v[cyc+3][ida] = 1'b1;
      sch_d[cyc+3][ida] = mem[ea];
    end
    if (idb >= 0) begin
      sch_v[cyc+3][idb] = 1'b1;
      sch_d[cyc+3][idb] = mem[eb];
    end
    if (ida >= 0) ptr_m = ((idb >= 0 ? idb : ida) + 1) % 4;
    cyc++;
  endtask

  initial begin
    logic [3:0]  g;
    logic [4:0]  en_hist;
    logic [3:0]  pend;
    logic [39:0] paddr;
    logic [39:0] ta;
    int          load;

    for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 37) ^ (i >> 3));
    mem[10'h01F] = 8'h74;
    mem[10'h03F] = 8'hFB;
    mem[10'h100] = 8'hEF;
    model_clear();
    do_reset();

    // Single request and EN gating window
    step(4'b0001, {30'h0, 10'h01F}, g);
    chk("single_gnt", g, 4'b0001);
    chk("single_addra", s_a, 10'h01F);
    en_hist[0] = s_en;
    for (int k = 1; k < 5; k++) begin
      step(4'b0000, 40'h0, g);
      en_hist[k] = s_en;
      if (k == 3) begin
        chk("single_rsp_valid", s_rv, 4'b0001);
        chk("single_rsp_data", s_rd[7:0], 8'h74);
      end
    end
    chk("single_en_window", en_hist, 5'b00111);

    // Dual request, both ports return together
    step(4'b0110, {10'h000, 10'h100, 10'h03F, 10'h000}, g);
    chk("dual_gnt", g, 4'b0110);
    chk("dual_ports", {s_a, s_b}, {10'h03F, 10'h100});
    for (int k = 1; k < 4; k++) step(4'b0000, 40'h0, g);
    chk("dual_rsp_valid", s_rv, 4'b0110);
    chk("dual_lane1", s_rd[15:8], 8'hFB);
    chk("dual_lane2", s_rd[23:16], 8'hEF);

    // Fairness table; reset first so the scan must restart at index 0
    do_reset();
    ta = {10'h333, 10'h222, 10'h111, 10'h0AA};
    tbl[0] = '{4'b1111, 4'b0011, 10'h0AA, 10'h111};
    tbl[1] = '{4'b1111, 4'b1100, 10'h222, 10'h333};
    tbl[2] = '{4'b1111, 4'b0011, 10'h0AA, 10'h111};
    tbl[3] = '{4'b1111, 4'b1100, 10'h222, 10'h333};
    tbl[4] = '{4'b1010, 4'b1010, 10'h111, 10'h333};
    tbl[5] = '{4'b0100, 4'b0100, 10'h222, 10'h000};
    tbl[6] = '{4'b1001, 4'b1001, 10'h333, 10'h0AA};
    tbl[7] = '{4'b0001, 4'b0001, 10'h0AA, 10'h000};
    for (int v = 0; v < 8; v++) begin
      step(tbl[v].r, ta, g);
      chk($sformatf("tbl%0d_gnt", v), g, tbl[v].g);
      chk($sformatf("tbl%0d_ports", v), {s_a, s_b}, {tbl[v].a, tbl[v].b});
    end
    for (int k = 0; k < 4; k++) step(4'b0000, 40'h0, g);

    // Streaming from one requester
    do_reset();
    for (int k = 0; k < 12; k++) begin
      step(k < 8 ? 4'b0001 : 4'b0000, {30'h0, 10'(k)}, g);
      if (k >= 3 && k <= 10) begin
        chk($sformatf("stream_rv%0d", k), s_rv, 4'b0001);
        chk($sformatf("stream_data%0d", k), s_rd[7:0], mem[k-3]);
      end else begin
        chk($sformatf("stream_rv%0d", k), s_rv, 4'b0000);
      end
    end

    // Reset one cycle after a grant: the lookup must vanish
    do_reset();
    step(4'b0001, {30'h0, 10'h01F}, g);
    chk("midrst_gnt", g, 4'b0001);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(4'b0000, 40'h0, g);
      chk($sformatf("midrst_rv%0d", k), s_rv, 4'b0000);
      chk($sformatf("midrst_en%0d", k), s_en, 1'b0);
    end
    step(4'b0010, {20'h0, 10'h055, 10'h0}, g);
    chk("midrst_wake_en", s_en, 1'b1);
    for (int k = 0; k < 4; k++) step(4'b0000, 40'h0, g);

    // Randomized traffic at varying load with a reset in the middle
    do_reset();
    pend  = '0;
    paddr = '0;
    for (int n = 0; n < 1500; n++) begin
      load = (n < 500) ? 30 : (n < 1000) ? 90 : 10;
      if (n == 750) begin
        do_reset();
        pend = '0;
      end
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < load) begin
          pend[i] = 1'b1;
          paddr[10*i +: 10] = 10'($urandom_range(0, 1023));
        end
      end
      step(pend, paddr, g);
      pend = pend & ~g;
    end
    for (int k = 0; k < 5; k++) step(4'b0000, 40'h0, g);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bram_lut_sched.md
BRAM_LUT_SCHED -- requirements
Module: bram_lut_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of lookup requesters (fixed at 4; other values unsupported).
REQ-002 SHALL have parameter LAT, default 2, meaning BRAM read latency in cycles (address registered plus DOA_REG/DOB_REG output register).
REQ-003 SHALL have port clk, input, 1, the single clock for the block and the BRAM.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req, input, 4, per-requester lookup request; held high until granted.
REQ-006 SHALL have port addr, input, 40, per-requester 10-bit table address; requester i uses bits [10i+9:10i].
REQ-007 SHALL have port gnt, output, 4, one-hot-per-port grant pulse, same cycle as the accepted req.
REQ-008 SHALL have port rsp_valid, output, 4, one-cycle pulse marking returned data for requester i.
REQ-009 SHALL have port rsp_data, output, 32, per-requester 8-bit lookup result; requester i uses bits [8i+7:8i].
REQ-010 SHALL have ports ADDRA/ADDRB, output, 10 each, BRAM port A/B addresses.
REQ-011 SHALL have port EN, output, 1, BRAM enable driving ENA/ENB/REGCEA/REGCEB.
REQ-012 SHALL have port bram_rst, output, 1, active-high BRAM output-register reset.
REQ-013 SHALL have ports DOA/DOB, input, 8 each, BRAM read data.
REQ-014 SHALL have port idle, output, 1, high when no request is pending and no lookup is in flight.

Function
REQ-015 SHALL keep a 2-bit round-robin pointer ptr; each cycle it scans req from index ptr upward, mod 4.
REQ-016 SHALL route the first requester found to port A and the second to port B; gnt is combinational for both winners.
REQ-017 SHALL drive ADDRA/ADDRB with the winners' addresses and 10'h000 for an unused port.
REQ-018 SHALL, at the clock edge after any grant, set ptr to (index of last granted requester + 1) mod 4; with no grant, ptr holds.
REQ-019 SHALL never grant one requester on both ports in the same cycle; one requester is granted at most once per cycle, which allows one grant per cycle back-to-back.
REQ-020 SHALL carry a tag {vA, idA[1:0], vB, idB[1:0]} through a LAT-deep shift register that advances only while EN=1.
REQ-021 SHALL, when the last tag stage is valid, register DOA into rsp_data[idA] and DOB into rsp_data[idB], and pulse the matching rsp_valid on the following cycle.
REQ-022 SHALL give a total latency of exactly 3 cycles: grant at cycle t, rsp_valid at cycle t+3.
REQ-023 SHALL hold rsp_data lanes unchanged when they are not written.
REQ-024 SHALL drive EN = |req OR any tag stage valid, which gates the BRAM off when idle.
REQ-025 SHALL allow both ports to return data for different requesters in the same cycle, with two rsp_valid bits set.
REQ-026 SHALL drive idle = ~EN.
REQ-027 SHALL leave a lone requester on port A only, with port B unused (vB=0).

Reset
REQ-028 SHALL, while rst=0, immediately clear ptr=0, all tag stages, rsp_valid=0 and rsp_data=0, which forces EN=0 and idle=1 regardless of req.
REQ-029 SHALL drive bram_rst=~rst, so the BRAM output registers clear asynchronously with the block.
REQ-030 SHALL discard in-flight lookups on reset mid-operation: no rsp_valid for requests granted before reset.
REQ-031 SHALL make the first grant after reset deassertion scan from index 0.

Verification
REQ-032 SHALL cover single request: req=4'b0001, addr0=10'h01F -> gnt=4'b0001 via port A; 3 cycles later rsp_valid=4'b0001 with rsp_data[7:0]=8'h74.
REQ-033 SHALL cover dual request: req=4'b0110, addr1=10'h03F, addr2=10'h100 -> ports A and B both used; rsp_valid=4'b0110, lane1=8'hFB, lane2=8'hEF in the same cycle.
REQ-034 SHALL cover fairness: req=4'b1111 held for 4 cycles -> grants 0011, 1100, 0011, 1100 with ptr cycling 2, 0, 2, 0.
REQ-035 SHALL cover streaming: req0 high for 8 cycles with addr 0..7 -> 8 consecutive rsp_valid pulses, data in address order, first at cycle 3.
REQ-036 SHALL cover mid-flight reset: rst=0 one cycle after a grant -> no rsp_valid; after release idle=1 and EN=0 until the next req.
REQ-037 SHALL cover idle gating: req=0 with pipeline empty -> EN=0 and idle=1; a single request -> EN high for exactly 3 cycles.
